turn_countdown: RTL and testbench



---
 rtl/turn_countdown.sv | 140 ++++++++++++++
 tb/tb_turn_countdown.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/turn_countdown.sv
// turn_countdown: per-turn countdown timer driven by a once-per-second tick.
// Counts TURN_SECONDS down to zero, keeping a binary count and a lockstep
// BCD digit pair for the display. It pulses `timeout` once on expiry and
// holds `expired` until the next start or stop.
module turn_countdown #(
  parameter int TURN_SECONDS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  output logic [6:0] seconds_left,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       expired,
  output logic       timeout
);

  // Reject an out-of-range turn length at elaboration.
  if (TURN_SECONDS < 1 || TURN_SECONDS > 99) begin : g_bad_turn_seconds
    $error("turn_countdown: TURN_SECONDS must be in 1..99");
  end

  localparam logic [6:0] SEC_INIT  = 7'(TURN_SECONDS);
  localparam logic [3:0] TENS_INIT = 4'(TURN_SECONDS / 10);
  localparam logic [3:0] ONES_INIT = 4'(TURN_SECONDS % 10);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t state;
  logic   tick_q;
  logic   tick_rise;

  // A held-high tick produces a single rising edge, so it counts only once.
  assign tick_rise = tick & ~tick_q;

  // Delay the tick by one cycle for edge detection.
  // NOTE: every register is written with <= so all flops in the block
  // update together from the values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= tick;
  end

  // Turn FSM with its registered count, BCD digits and status flags.
  // NOTE: reset is synchronous and reaches every register here, so the
  // first edge with rst high forces IDLE and a reload over all other inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      seconds_left <= SEC_INIT;
      tens         <= TENS_INIT;
      ones         <= ONES_INIT;
      running      <= 1'b0;
      expired      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      // The expiry pulse lasts a single cycle unless re-asserted below.
      timeout <= 1'b0;

      if (stop) begin
        state        <= S_IDLE;
        seconds_left <= SEC_INIT;
        tens         <= TENS_INIT;
        ones         <= ONES_INIT;
        running      <= 1'b0;
        expired      <= 1'b0;
      end else if (start) begin
        // Begin or restart a turn from any state; a coincident tick is lost.
        state        <= S_RUN;
        seconds_left <= SEC_INIT;
        tens         <= TENS_INIT;
        ones         <= ONES_INIT;
        running      <= 1'b1;
        expired      <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            // Waiting for a start; ticks are ignored and the count stays loaded.
          end

          S_RUN: begin
            if (hold) begin
              // Pausing takes precedence over a tick on the same edge.
              state   <= S_PAUSED;
              running <= 1'b0;
            end else if (tick_rise) begin
              if (seconds_left == 7'd1) begin
                seconds_left <= 7'd0;
                tens         <= 4'd0;
                ones         <= 4'd0;
                state        <= S_EXPIRED;
                running      <= 1'b0;
                expired      <= 1'b1;
                timeout      <= 1'b1;
              end else begin
                seconds_left <= seconds_left - 7'd1;
                // Digits count down in lockstep: ones wraps 0 -> 9 and
                // borrows from tens.
                if (ones == 4'd0) begin
                  ones <= 4'd9;
                  tens <= tens - 4'd1;
                end else begin
                  ones <= ones - 4'd1;
                end
              end
            end
          end

          S_PAUSED: begin
            // Ticks arriving while paused are dropped rather than queued.
            if (!hold) begin
              state   <= S_RUN;
              running <= 1'b1;
            end
          end

          S_EXPIRED: begin
            // The count holds at zero until start or stop.
          end

          default: begin
            state   <= S_IDLE;
            running <= 1'b0;
            expired <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_turn_countdown.sv
// Testbench for turn_countdown: two instances (15 s and 1 s turns) share one
// stimulus stream. A turn-level reference model predicts every output on
// every cycle. Directed scenarios plus a randomized run are checked against it.
module tb_turn_countdown;

  logic clk = 1'b0;
  logic rst, tick, start, stop, hold;

  logic [6:0] sec_a,  sec_b;
  logic [3:0] tens_a, tens_b, ones_a, ones_b;
  logic       run_a, run_b, exp_a, exp_b, to_a, to_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  turn_countdown #(.TURN_SECONDS(15)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .hold(hold),
    .seconds_left(sec_a), .tens(tens_a), .ones(ones_a),
    .running(run_a), .expired(exp_a), .timeout(to_a)
  );

  turn_countdown #(.TURN_SECONDS(1)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .hold(hold),
    .seconds_left(sec_b), .tens(tens_b), .ones(ones_b),
    .running(run_b), .expired(exp_b), .timeout(to_b)
  );

  // ---------------- reference model ----------------
  typedef enum {P_IDLE, P_RUN, P_PAUSED, P_EXPIRED} phase_t;

  int     m_len  [2] = '{15, 1};
  int     m_rem  [2];
  phase_t m_phase[2];
  bit     m_to   [2];
  bit     m_prev;

  // Advance the turn model by one clock edge using the current inputs.
  task automatic model_edge();
    bit rise;
    rise = tick && !m_prev;
    m_prev = rst ? 1'b0 : tick;
    for (int i = 0; i < 2; i++) begin
      m_to[i] = 1'b0;
      if (rst || stop) begin
        m_phase[i] = P_IDLE;
        m_rem[i]   = m_len[i];
      end else if (start) begin
        m_phase[i] = P_RUN;
        m_rem[i]   = m_len[i];
      end else if (m_phase[i] == P_RUN) begin
        if (hold) m_phase[i] = P_PAUSED;
        else if (rise) begin
          m_rem[i] = m_rem[i] - 1;
          if (m_rem[i] == 0) begin
            m_phase[i] = P_EXPIRED;
            m_to[i]    = 1'b1;
          end
        end
      end else if (m_phase[i] == P_PAUSED && !hold) begin
        m_phase[i] = P_RUN;
      end
    end
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic compare_all();
    check("a_sec",   sec_a,  m_rem[0]);
    check("a_tens",  tens_a, m_rem[0] / 10);
    check("a_ones",  ones_a, m_rem[0] % 10);
    check("a_run",   run_a,  int'(m_phase[0] == P_RUN));
    check("a_exp",   exp_a,  int'(m_phase[0] == P_EXPIRED));
    check("a_to",    to_a,   int'(m_to[0]));
    check("b_sec",   sec_b,  m_rem[1]);
    check("b_tens",  tens_b, m_rem[1] / 10);
    check("b_ones",  ones_b, m_rem[1] % 10);
    check("b_run",   run_b,  int'(m_phase[1] == P_RUN));
    check("b_exp",   exp_b,  int'(m_phase[1] == P_EXPIRED));
    check("b_to",    to_b,   int'(m_to[1]));
  endtask

  // One clock edge: model follows the edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // One-cycle tick pulse followed by low cycles up to the given spacing.
  task automatic pulse(input int gap);
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int to_cycles;

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
    m_prev = 1'b0;
    step();
    // Reset values from constants.
    check("rst_sec",  sec_a, 15);
    check("rst_tens", tens_a, 1);
    check("rst_ones", ones_a, 5);
    check("rst_flags", {run_a, exp_a, to_a}, 0);
    rst = 1'b0;
    idle(2);

    // Full turn: 15 pulses, 10 cycles apart; timeout exactly one cycle.
    do_start();
    to_cycles = 0;
    for (int k = 0; k < 15; k++) begin
      tick = 1'b1;
      step();
      if (to_a) to_cycles++;
      tick = 1'b0;
      for (int j = 0; j < 9; j++) begin
        step();
        if (to_a) to_cycles++;
      end
    end
    check("full_timeout_cycles", to_cycles, 1);
    check("full_sec", sec_a, 0);
    check("full_expired", exp_a, 1);
    check("full_running", run_a, 0);
    pulse(3);
    check("exp_hold_zero", sec_a, 0);

    // Tick held high for 30 cycles counts once, on the first high edge.
    do_start();
    tick = 1'b1;
    step();
    check("held_first_edge", sec_a, 14);
    idle(29);
    tick = 1'b0;
    step();
    check("held_once", sec_a, 14);

    // Down to 10, then pause across three ticks.
    repeat (4) pulse(4);
    check("at10", sec_a, 10);
    hold = 1'b1;
    repeat (3) pulse(4);
    check("paused_sec", sec_a, 10);
    check("paused_run", run_a, 0);
    hold = 1'b0;
    step();
    pulse(4);
    check("resume_sec", sec_a, 9);
    check("resume_run", run_a, 1);

    // At 5, start and tick together: reload, no decrement.
    repeat (4) pulse(4);
    check("at5", sec_a, 5);
    start = 1'b1; tick = 1'b1;
    step();
    start = 1'b0; tick = 1'b0;
    check("restart_sec", sec_a, 15);
    step();
    repeat (15) pulse(3);
    check("expired_again", exp_a, 1);
    do_start();
    check("exp_restart_sec", sec_a, 15);
    check("exp_restart_run", run_a, 1);

    // At 7, stop and start together: stop wins.
    repeat (8) pulse(3);
    check("at7", sec_a, 7);
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    check("stop_wins_sec", sec_a, 15);
    check("stop_wins_run", run_a, 0);
    repeat (3) pulse(3);
    check("idle_ignores_ticks", sec_a, 15);

    // At 3, reset mid-turn.
    do_start();
    repeat (12) pulse(3);
    check("at3", sec_a, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_sec", sec_a, 15);
    check("midrst_flags", {run_a, exp_a, to_a}, 0);

    // One-second turn: a single tick expires it.
    do_start();
    tick = 1'b1;
    step();
    check("one_sec_zero", sec_b, 0);
    check("one_sec_timeout", to_b, 1);
    tick = 1'b0;
    step();
    check("one_sec_timeout_drop", to_b, 0);
    check("one_sec_expired", exp_b, 1);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 59) == 0);
      stop  = ($urandom_range(0, 89) == 0);
      if ($urandom_range(0, 24) == 0) hold = ~hold;
      if ($urandom_range(0, 2) == 0) tick = ~tick;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
